// File: rtl/hazard_forward_unit_pkg.sv
// rtl/hazard_forward_unit_pkg.sv - shared widths, forward-select encodings and tracker slot type
package hazard_forward_unit_pkg;

    localparam int REG_FILE_ADDR_LEN = 5;

    // Operand mux select encodings, consumed unchanged by the EX operand muxes
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef struct packed {
        logic                         valid;
        logic [REG_FILE_ADDR_LEN-1:0] dest;
        logic                         wb_en;
        logic                         is_load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_FLUSH
    } state_t;

    // A slot produces a source only if it will really write a non-zero register
    function automatic logic slot_match(input slot_t s, input logic [REG_FILE_ADDR_LEN-1:0] src);
        return s.valid && s.wb_en && (s.dest == src) && (s.dest != '0);
    endfunction

    // Newest producer wins: the instruction now in EX will sit in MEM when the consumer executes
    function automatic logic [1:0] fwd_select(input slot_t ex, input slot_t mem,
                                              input logic [REG_FILE_ADDR_LEN-1:0] src);
        if (slot_match(ex, src)) begin
            return FWD_MEM;
        end
        if (slot_match(mem, src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_forward_unit_slot.sv
// rtl/hazard_forward_unit_slot.sv - one pipeline tracker slot with bubble load
module hazard_slot
    import hazard_forward_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_load,
    input  slot_t i_slot,
    output slot_t o_slot
);

    slot_t r_slot;

    // Capture the incoming entry, or a bubble when the load is suppressed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= SLOT_BUBBLE;
        end else if (i_load) begin
            r_slot <= i_slot;
        end else begin
            r_slot <= SLOT_BUBBLE;
        end
    end

    assign o_slot = r_slot;

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - load-use stall, branch flush and EX operand forwarding control
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [REG_FILE_ADDR_LEN-1:0] id_src1,
    input  logic [REG_FILE_ADDR_LEN-1:0] id_src2,
    input  logic                         id_uses_src2,
    input  logic [REG_FILE_ADDR_LEN-1:0] id_dest,
    input  logic                         id_wb_en,
    input  logic                         id_is_load,
    input  logic                         branch_taken,
    output logic [1:0]                   fwd_sel1,
    output logic [1:0]                   fwd_sel2,
    output logic                         stall,
    output logic                         flush,
    output logic [15:0]                  stall_cnt,
    output logic [15:0]                  flush_cnt
);

    slot_t       w_id;
    slot_t       w_ex;
    slot_t       w_mem;
    slot_t       w_wb;
    logic        w_load_use;
    logic        w_ex_load;
    logic        w_unused;
    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_fwd_sel1;
    logic [1:0]  r_fwd_sel2;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    assign w_id = '{valid: id_valid, dest: id_dest, wb_en: id_wb_en, is_load: id_is_load};

    // A load in EX cannot forward its data to the very next instruction
    assign w_load_use = id_valid && w_ex.is_load &&
                        (slot_match(w_ex, id_src1) || (id_uses_src2 && slot_match(w_ex, id_src2)));

    // Stall/flush outputs and next state; a taken branch overrides any pending stall
    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        flush        = 1'b0;
        if (!rst) begin
            flush = branch_taken;
            stall = (r_state == ST_RUN) && w_load_use && !branch_taken;
        end
        if (branch_taken) begin
            w_state_next = ST_FLUSH;
        end else begin
            case (r_state)
                ST_RUN:   w_state_next = stall ? ST_STALL : ST_RUN;
                ST_STALL: w_state_next = ST_RUN;
                ST_FLUSH: w_state_next = ST_RUN;
                default:  w_state_next = ST_RUN;
            endcase
        end
    end

    // Hazard FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_ex_load = id_valid && !stall && !flush;

    hazard_slot u_slot_ex (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_ex_load),
        .i_slot (w_id),
        .o_slot (w_ex)
    );

    hazard_slot u_slot_mem (
        .clk    (clk),
        .rst    (rst),
        .i_load (1'b1),
        .i_slot (w_ex),
        .o_slot (w_mem)
    );

    hazard_slot u_slot_wb (
        .clk    (clk),
        .rst    (rst),
        .i_load (1'b1),
        .i_slot (w_mem),
        .o_slot (w_wb)
    );

    // Forward selects are decided as the instruction enters EX; bubbles read the register file
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_sel1 <= FWD_RF;
            r_fwd_sel2 <= FWD_RF;
        end else if (w_ex_load) begin
            r_fwd_sel1 <= fwd_select(w_ex, w_mem, id_src1);
            r_fwd_sel2 <= id_uses_src2 ? fwd_select(w_ex, w_mem, id_src2) : FWD_RF;
        end else begin
            r_fwd_sel1 <= FWD_RF;
            r_fwd_sel2 <= FWD_RF;
        end
    end

    // Saturating performance counters for stall and flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign fwd_sel1  = r_fwd_sel1;
    assign fwd_sel2  = r_fwd_sel2;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    // The WB slot only retires entries, and MEM never needs its load flag
    assign w_unused = &{1'b0, w_wb, w_mem.is_load};

endmodule
